// File: rtl/multicycle_controller.sv
// Control FSM sequencing a shared single-ALU, single-memory RV32I datapath (lw, sw, R, I-ALU, beq, jal).
// Latency: lw 5, sw/R/I/jal 4, beq 3 cycles with memory always ready; each memory wait cycle adds one.
// Backpressure: FETCH, MEMREAD and MEMWRITE hold their outputs until mem_ready; other states ignore it.
//
// Ports:
//   clk, rst_n            clock (rising edge), asynchronous active-low reset
//   op, zero, mem_ready   opcode from IR, ALU zero flag, memory completion strobe
//   mem_req, adr_src, mem_write, ir_write, pc_write, reg_write   datapath enables
//   result_src, alu_src_a, alu_src_b, alu_op, imm_src            datapath mux/ALU selects
//   illegal_op            one-cycle flag for an unsupported opcode seen in DECODE
//   instret               retired-instruction counter, wraps modulo 2^CNT_W
module multicycle_controller #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [6:0]       op,
  input  logic             zero,
  input  logic             mem_ready,
  output logic             mem_req,
  output logic             adr_src,
  output logic             mem_write,
  output logic             ir_write,
  output logic             pc_write,
  output logic             reg_write,
  output logic [1:0]       result_src,
  output logic [1:0]       alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [1:0]       alu_op,
  output logic [1:0]       imm_src,
  output logic             illegal_op,
  output logic [CNT_W-1:0] instret
);

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;

  typedef enum logic [3:0] {
    S_IDLE     = 4'd0,
    S_FETCH    = 4'd1,
    S_DECODE   = 4'd2,
    S_MEMADR   = 4'd3,
    S_MEMREAD  = 4'd4,
    S_MEMWB    = 4'd5,
    S_MEMWRITE = 4'd6,
    S_EXECR    = 4'd7,
    S_EXECI    = 4'd8,
    S_ALUWB    = 4'd9,
    S_BEQ      = 4'd10,
    S_JAL      = 4'd11
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] instret_q, instret_d;
  logic             retire;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      instret_q <= '0;
    end else begin
      state_q   <= state_d;
      instret_q <= instret_d;
    end
  end

  // Immediate format follows the opcode in every state so the extender is
  // already settled when DECODE computes the branch target.
  always_comb begin
    imm_src = 2'b00;
    case (op)
      OP_SW:   imm_src = 2'b01;
      OP_BEQ:  imm_src = 2'b10;
      OP_JAL:  imm_src = 2'b11;
      default: imm_src = 2'b00;
    endcase
  end

  // Next state and Moore outputs. mem_ready only gates FETCH enables and
  // memory-state exits; zero only drives pc_write in BEQ.
  always_comb begin
    state_d    = state_q;
    retire     = 1'b0;
    mem_req    = 1'b0;
    adr_src    = 1'b0;
    mem_write  = 1'b0;
    ir_write   = 1'b0;
    pc_write   = 1'b0;
    reg_write  = 1'b0;
    result_src = 2'b00;
    alu_src_a  = 2'b00;
    alu_src_b  = 2'b00;
    alu_op     = 2'b00;
    illegal_op = 1'b0;
    case (state_q)
      S_IDLE: state_d = S_FETCH;
      S_FETCH: begin
        mem_req    = 1'b1;
        alu_src_b  = 2'b10;
        result_src = 2'b10;
        ir_write   = mem_ready;
        pc_write   = mem_ready;
        if (mem_ready) state_d = S_DECODE;
      end
      S_DECODE: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b01;
        case (op)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_R:         state_d = S_EXECR;
          OP_I:         state_d = S_EXECI;
          OP_BEQ:       state_d = S_BEQ;
          OP_JAL:       state_d = S_JAL;
          default: begin
            // Unsupported opcode: flag it and drop the instruction unretired.
            illegal_op = 1'b1;
            state_d    = S_FETCH;
          end
        endcase
      end
      S_MEMADR: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
        state_d   = (op == OP_LW) ? S_MEMREAD : S_MEMWRITE;
      end
      S_MEMREAD: begin
        mem_req = 1'b1;
        adr_src = 1'b1;
        if (mem_ready) state_d = S_MEMWB;
      end
      S_MEMWB: begin
        result_src = 2'b01;
        reg_write  = 1'b1;
        retire     = 1'b1;
        state_d    = S_FETCH;
      end
      S_MEMWRITE: begin
        mem_req   = 1'b1;
        adr_src   = 1'b1;
        mem_write = 1'b1;
        if (mem_ready) begin
          retire  = 1'b1;
          state_d = S_FETCH;
        end
      end
      S_EXECR: begin
        alu_src_a = 2'b10;
        alu_op    = 2'b10;
        state_d   = S_ALUWB;
      end
      S_EXECI: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
        alu_op    = 2'b10;
        state_d   = S_ALUWB;
      end
      S_ALUWB: begin
        reg_write = 1'b1;
        retire    = 1'b1;
        state_d   = S_FETCH;
      end
      S_BEQ: begin
        alu_src_a = 2'b10;
        alu_op    = 2'b01;
        pc_write  = zero;
        retire    = 1'b1;
        state_d   = S_FETCH;
      end
      S_JAL: begin
        // PC takes the target held in ALUOut; rd = OldPC+4 is written in
        // ALUWB, which is also where jal retires.
        alu_src_a = 2'b01;
        alu_src_b = 2'b10;
        pc_write  = 1'b1;
        state_d   = S_ALUWB;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign instret_d = instret_q + {{(CNT_W-1){1'b0}}, retire};
  assign instret   = instret_q;

endmodule
